pingpong_bank_writer: RTL
=========================

// Module: pingpong_bank_writer
// PURPOSE
//  Write-side front end for the ping-pong frame RAMs. Accepts a valid/ready byte stream,
//  fills RAM bank 0 and RAM bank 1 alternately, and hands each completed bank to the display reader.
//  Reader returns a bank with a one-cycle release pulse. Replaces ad-hoc write control with a
//  back-pressured handshake, so no bank is overwritten while the reader owns it.
// PARAMETERS
//  DATA_W  8   stream and RAM word width
//  ADDR_W  5   RAM address width; bank depth = 2**ADDR_W (32)
// PORTS
//  clk          in   1         single clock; all logic rising-edge
//  reset        in   1         asynchronous, active-high
//  in_valid     in   1         producer word valid
//  in_data      in   DATA_W    producer word
//  in_last      in   1         qualified by in_valid; word closes current bank early
//  in_ready     out  1         writer can accept word this cycle
//  wr_en        out  2         per-bank RAM write enable, one-hot or 0
//  wr_addr      out  ADDR_W    RAM write address (shared by both banks)
//  wr_data      out  DATA_W    RAM write data (shared by both banks)
//  bank_ready   out  2         bank i holds a committed frame owned by reader
//  bank_len0    out  ADDR_W+1  committed word count of bank 0 (1..2**ADDR_W)
//  bank_len1    out  ADDR_W+1  committed word count of bank 1
//  rd_release   in   2         reader pulse: bank i is free again
//  fill_bank    out  1         bank currently being filled
//  release_err  out  1         sticky: release seen for a bank that was not ready
// BEHAVIOUR
//  Reset (async): state=FILL, fill_bank=0, count=0, wr_en=00, wr_addr=0, wr_data=0,
//   bank_ready=00, bank_len0/1=0, release_err=0, commit_pend=0. in_ready=1 once reset deasserts.
//  in_ready = (state==FILL) & ~bank_ready[fill_bank]. This is combinational from registers only.
//  Accept = in_valid & in_ready. On accept edge: wr_en[fill_bank]<=1, wr_addr<=count,
//   wr_data<=in_data, count<=count+1. The RAM write lands on the next edge (1-cycle latency).
//   Without accept, wr_en<=00. wr_addr and wr_data hold their values.
//  Close: accept with in_last=1 or count==2**ADDR_W-1. On the close edge:
//   - latch len=count+1 into bank_len[fill_bank];
//   - set commit_pend with bank id; toggle fill_bank; count<=0.
//  Commit: the edge after close sets bank_ready[id]. Ready is never visible before the last
//   write has landed. The reader sees bank_ready exactly 2 edges after the closing accept.
//  After close, if bank_ready[new fill_bank]=1, then state<=WAIT_FREE and in_ready=0.
//   Return to FILL on the edge where that bank is released.
//  rd_release[i] with bank_ready[i]=1 clears bank_ready[i] next edge. bank_len[i] holds.
//   rd_release[i] with bank_ready[i]=0 is ignored and sets release_err.
//  Simultaneous events:
//   - release of bank A with commit of bank B: both apply.
//   - release arriving in the same cycle as the switch to WAIT_FREE: FILL continues without a stall cycle.
//   - rd_release=11: each bit is handled independently.
//  count wraps only through close; count never exceeds 2**ADDR_W-1. in_last on the word at
//   address 2**ADDR_W-1 is one close, not two.
//  in_last without in_valid: ignored. An empty bank is never committed.
//  Reset mid-fill drops the partial bank: no commit, and wr_en clears immediately (async).
// STRUCTURE
//  Shared package (pingpong_pkg): DATA_W, ADDR_W, BANK0=1'b0, BANK1=1'b1, state encodings
//   FILL=1'b0 and WAIT_FREE=1'b1.
//  One sub-module: bank_owner_tracker. It holds bank_ready[1:0], the commit/release arbitration
//   and release_err. The parent holds the address counter, the FSM and the write pipeline.
// TESTING
//  1. Stream 32 words 0x00..0x1F, no release:
//     - wr_en=01 with addr 0..31;
//     - bank_ready=01 two edges after the last accept; bank_len0=32; fill_bank=1.
//  2. Continue 32 more words without release:
//     - bank 1 fills and commits; bank_ready=11;
//     - in_ready=0 (WAIT_FREE); further in_valid produces no wr_en.
//  3. From case 2, pulse rd_release=01:
//     - bank_ready=10; in_ready=1 next cycle; next word writes bank 0 at addr 0.
//  4. 5 words with in_last on the 5th:
//     - bank_len=5; commit 2 edges later; next word goes to the other bank, addr 0.
//  5. rd_release=10 while bank_ready=00:
//     - release_err=1, which stays set; bank_ready stays 00; stream unaffected.
//  6. Assert reset after 10 words into bank 0:
//     - all outputs return to reset values; no commit; the next stream starts at bank 0, addr 0.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared constants and types for the ping-pong bank writer.
package pingpong_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_FREE = 1'b1
  } state_e;
endpackage

// File: rtl/bank_owner_tracker.sv
// Tracks which banks the reader owns: commits from the writer set a bank,
// reader releases clear it. A release of a bank the reader does not own is
// ignored and flagged in a sticky error bit.
module bank_owner_tracker
  import pingpong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       commit_pend,
  input  logic       commit_id,
  input  logic [1:0] rd_release,
  output logic [1:0] bank_ready,
  output logic [1:0] bank_ready_next,
  output logic       release_err
);

  logic [1:0] bank_ready_q, bank_ready_d;
  logic       release_err_q, release_err_d;

  // Next ownership: each release bit acts on its own bank; a pending commit
  // always targets the other bank than any legal release, so both apply.
  always_comb begin
    bank_ready_d  = bank_ready_q;
    release_err_d = release_err_q;
    for (int i = 0; i < 2; i++) begin
      if (rd_release[i]) begin
        if (bank_ready_q[i]) bank_ready_d[i] = 1'b0;
        else                 release_err_d   = 1'b1;
      end
    end
    if (commit_pend) bank_ready_d[commit_id] = 1'b1;
  end

  // Ownership and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_ready_q  <= 2'b00;
      release_err_q <= 1'b0;
    end else begin
      bank_ready_q  <= bank_ready_d;
      release_err_q <= release_err_d;
    end
  end

  assign bank_ready      = bank_ready_q;
  assign bank_ready_next = bank_ready_d;
  assign release_err     = release_err_q;

endmodule

// File: rtl/pingpong_bank_writer.sv
// Write-side front end for the ping-pong frame RAMs.
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high; in_ready depends on registers only, and in_data/in_last are
// ignored whenever in_valid is low.
module pingpong_bank_writer
  import pingpong_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [1:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        bank_ready,
  output logic [ADDR_W:0]   bank_len0,
  output logic [ADDR_W:0]   bank_len1,
  input  logic [1:0]        rd_release,
  output logic              fill_bank,
  output logic              release_err,
  output state_e            state_dbg
);

  state_e            state_q, state_d;
  logic              fill_bank_q, fill_bank_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [1:0]        wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W:0]   len0_q, len0_d;
  logic [ADDR_W:0]   len1_q, len1_d;
  logic              commit_pend_q, commit_pend_d;
  logic              commit_id_q, commit_id_d;

  logic [1:0] ready_now, ready_next;
  logic       accept, at_end, close;

  bank_owner_tracker u_tracker (
    .clk            (clk),
    .reset          (reset),
    .commit_pend    (commit_pend_q),
    .commit_id      (commit_id_q),
    .rd_release     (rd_release),
    .bank_ready     (ready_now),
    .bank_ready_next(ready_next),
    .release_err    (release_err)
  );

  assign in_ready = (state_q == FILL) && !ready_now[fill_bank_q];
  assign accept   = in_valid && in_ready;
  assign at_end   = (count_q == ADDR_W'(DEPTH - 1));
  // A last word landing on the final address is a single close.
  assign close    = accept && (in_last || at_end);

  // Write pipeline, address counter, bank close and fill-state decisions.
  always_comb begin
    state_d       = state_q;
    fill_bank_d   = fill_bank_q;
    count_d       = count_q;
    wr_en_d       = 2'b00;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    len0_d        = len0_q;
    len1_d        = len1_q;
    commit_pend_d = 1'b0;
    commit_id_d   = commit_id_q;

    if (accept) begin
      wr_en_d[fill_bank_q] = 1'b1;
      wr_addr_d            = count_q;
      wr_data_d            = in_data;
      count_d              = count_q + ADDR_W'(1);
    end

    if (close) begin
      if (fill_bank_q == BANK0) len0_d = {1'b0, count_q} + (ADDR_W + 1)'(1);
      else                      len1_d = {1'b0, count_q} + (ADDR_W + 1)'(1);
      commit_pend_d = 1'b1;
      commit_id_d   = fill_bank_q;
      fill_bank_d   = ~fill_bank_q;
      count_d       = '0;
    end

    // Stall only if the next bank is still owned after this edge, so a
    // release arriving together with the switch costs no cycle.
    case (state_q)
      FILL:      if (close && ready_next[~fill_bank_q]) state_d = WAIT_FREE;
      WAIT_FREE: if (!ready_next[fill_bank_q])          state_d = FILL;
      default:   state_d = FILL;
    endcase
  end

  // All writer state; reset drops any partial bank immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      fill_bank_q   <= BANK0;
      count_q       <= '0;
      wr_en_q       <= 2'b00;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      len0_q        <= '0;
      len1_q        <= '0;
      commit_pend_q <= 1'b0;
      commit_id_q   <= BANK0;
    end else begin
      state_q       <= state_d;
      fill_bank_q   <= fill_bank_d;
      count_q       <= count_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      len0_q        <= len0_d;
      len1_q        <= len1_d;
      commit_pend_q <= commit_pend_d;
      commit_id_q   <= commit_id_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign bank_ready = ready_now;
  assign bank_len0  = len0_q;
  assign bank_len1  = len1_q;
  assign fill_bank  = fill_bank_q;
  assign state_dbg  = state_q;

endmodule
